// File: rtl/mem_io_pkg.sv
// Shared address map and region decode for the memory/I-O responder.
package mem_io_pkg;

   localparam int unsigned DEC_W = 18;

   localparam logic [DEC_W-1:0] IO_UART = 18'h30000;
   localparam logic [DEC_W-1:0] IO_CLK  = 18'h30004;
   localparam logic [DEC_W-1:0] RAM_TOP = 18'h20000;

   typedef enum logic [1:0] {
      REGION_RAM  = 2'd0,
      REGION_IO   = 2'd1,
      REGION_NONE = 2'd2
   } region_e;

   // Below RAM_TOP is RAM, the top quarter is I/O, the rest is unmapped.
   function automatic region_e decode_region(input logic [DEC_W-1:0] a);
      if (a < RAM_TOP) begin
         return REGION_RAM;
      end else if (a[DEC_W-1:DEC_W-2] == 2'b11) begin
         return REGION_IO;
      end else begin
         return REGION_NONE;
      end
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with power-of-two depth; a pop when empty reads 0x00 and has no effect.
module byte_fifo #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        push,
   input  logic [7:0]                  din,
   input  logic                        pop,
   output logic [7:0]                  dout,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a push when a pop frees a slot in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_io_responder.sv
// CPU-side byte RAM plus UART FIFOs, halt flag and optional cycle counter.
// Define MEM_IO_CYCLE_COUNTER_EN to build the counter/snapshot at 0x30004-0x30007.
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int unsigned RAM_ADDR_W = 17,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        tx_full,
   output logic        halt
);
   localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_W;
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

   logic [DEC_W-1:0]      addr;
   logic [RAM_ADDR_W-1:0] ram_idx;
   region_e               region;
   logic                  is_uart;
   logic                  is_clk;
   logic                  unused_addr_hi;

   logic [7:0]            ram [RAM_BYTES];
   logic [7:0]            rd_data_c;

   logic                  rx_full;
   logic                  rx_pop;
   logic [7:0]            rx_dout;
   logic                  unused_rx_empty;
   logic [CNT_W-1:0]      unused_rx_count;

   logic                  tx_push;
   logic [7:0]            tx_din;
   logic                  tx_empty;
   logic [CNT_W-1:0]      unused_tx_count;

   assign addr           = mem_a[DEC_W-1:0];
   assign unused_addr_hi = ^mem_a[31:DEC_W];
   assign ram_idx        = addr[RAM_ADDR_W-1:0];
   assign region         = decode_region(addr);
   assign is_uart        = (addr == IO_UART);
   assign is_clk         = (addr == IO_CLK);

   assign rx_ready = !rx_full;
   assign rx_pop   = !mem_wr && is_uart;

   // Halt blocks every later TX push, including a repeated halt write.
   assign tx_push  = mem_wr && !halt && ((is_uart && (mem_dout != 8'h00)) || is_clk);
   assign tx_din   = is_clk ? 8'h00 : mem_dout;
   assign tx_valid = !tx_empty;

   byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (rx_valid && rx_ready),
      .din    (rx_data),
      .pop    (rx_pop),
      .dout   (rx_dout),
      .full   (rx_full),
      .empty  (unused_rx_empty),
      .count  (unused_rx_count)
   );

   byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (tx_push),
      .din    (tx_din),
      .pop    (tx_valid && tx_ready),
      .dout   (tx_data),
      .full   (tx_full),
      .empty  (tx_empty),
      .count  (unused_tx_count)
   );

`ifdef MEM_IO_CYCLE_COUNTER_EN
   logic [31:0] cycle_cnt;
   logic [23:0] snap_hi;
   logic        is_clk_hi;

   assign is_clk_hi = (addr[DEC_W-1:2] == IO_CLK[DEC_W-1:2]) && (addr[1:0] != 2'd0);

   // Byte 0 is returned live; only the upper three bytes need holding.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cycle_cnt <= 32'd0;
         snap_hi   <= 24'd0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (!mem_wr && is_clk) snap_hi <= cycle_cnt[31:8];
      end
   end
`endif

   always_comb begin
      rd_data_c = 8'h00;
      case (region)
         REGION_RAM: rd_data_c = ram[ram_idx];
         REGION_IO: begin
            if (is_uart) begin
               rd_data_c = rx_dout;
            end
`ifdef MEM_IO_CYCLE_COUNTER_EN
            else if (is_clk) begin
               rd_data_c = cycle_cnt[7:0];
            end else if (is_clk_hi) begin
               case (addr[1:0])
                  2'd1:    rd_data_c = snap_hi[7:0];
                  2'd2:    rd_data_c = snap_hi[15:8];
                  default: rd_data_c = snap_hi[23:16];
               endcase
            end
`endif
         end
         default: ;
      endcase
   end

   // Read data lands one cycle after the address; writes leave it untouched.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         mem_din <= 8'h00;
         halt    <= 1'b0;
      end else begin
         if (!mem_wr)          mem_din <= rd_data_c;
         if (mem_wr && is_clk) halt    <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (mem_wr && (region == REGION_RAM)) ram[ram_idx] <= mem_dout;
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder; expected reads and TX bytes are queued at issue time.
module tb_mem_io_responder;

   logic        clk_in;
   logic        rst_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        tx_full;
   logic        halt;

   logic        chk_req;
   logic        chk_d;
   logic [7:0]  rd_exp [$];
   logic [7:0]  tx_exp [$];
   int          n_cmp;
   int          n_err;

   localparam logic [31:0] A_UART = 32'h0003_0000;
   localparam logic [31:0] A_CLK  = 32'h0003_0004;

`ifdef MEM_IO_CYCLE_COUNTER_EN
   localparam logic [7:0] C100_B0 = 8'h64;
   localparam logic [7:0] C303_B0 = 8'h2F;
   localparam logic [7:0] C303_B1 = 8'h01;
`else
   localparam logic [7:0] C100_B0 = 8'h00;
   localparam logic [7:0] C303_B0 = 8'h00;
   localparam logic [7:0] C303_B1 = 8'h00;
`endif

   mem_io_responder dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .mem_a    (mem_a),
      .mem_wr   (mem_wr),
      .mem_dout (mem_dout),
      .mem_din  (mem_din),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx_full  (tx_full),
      .halt     (halt)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One bus cycle: everything driven on the falling edge.
   task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic rxv, input logic [7:0] rxd,
                      input logic chk, input logic [7:0] exp);
      @(negedge clk_in);
      mem_a    = a;
      mem_wr   = wr;
      mem_dout = d;
      rx_valid = rxv;
      rx_data  = rxd;
      chk_req  = chk;
      if (chk) rd_exp.push_back(exp);
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] exp);
      cyc(a, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      cyc(a, 1'b1, d, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic idle();
      cyc(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic rxp(input logic [7:0] b);
      cyc(32'h0, 1'b0, 8'h00, 1'b1, b, 1'b0, 8'h00);
   endtask

   always @(posedge clk_in) chk_d <= chk_req;

   // Monitor: read data one cycle after a checked read, TX bytes on each handshake.
   always @(negedge clk_in) begin
      #2;
      if (chk_d === 1'b1) begin
         if (rd_exp.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rd_unexpected: got 0x%0h, want no read at %0t", mem_din, $time);
         end else begin
            cmp("rd_data", 32'(mem_din), 32'(rd_exp.pop_front()));
         end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         if (tx_exp.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_unexpected: got 0x%0h, want no TX byte at %0t", tx_data, $time);
         end else begin
            cmp("tx_data", 32'(tx_data), 32'(tx_exp.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst_in   = 1'b0;
      mem_a    = 32'h0;
      mem_wr   = 1'b0;
      mem_dout = 8'h00;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b0;
      chk_req  = 1'b0;

      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      cmp("rst_mem_din",  32'(mem_din),  32'h00);
      cmp("rst_rx_ready", 32'(rx_ready), 32'h1);
      cmp("rst_tx_valid", 32'(tx_valid), 32'h0);
      cmp("rst_tx_full",  32'(tx_full),  32'h0);
      cmp("rst_halt",     32'(halt),     32'h0);

      // Counter: 100 edges after the last reset edge, sample at the 101st.
      repeat (100) @(posedge clk_in);
      rd(A_CLK, C100_B0);
      rd(32'h0003_0005, 8'h00);
      for (int i = 0; i < 200; i++) idle();
      rd(32'h0003_0005, 8'h00);
      rd(A_CLK, C303_B0);
      rd(32'h0003_0005, C303_B1);
      rd(32'h0003_0006, 8'h00);
      rd(32'h0003_0007, 8'h00);

      // RAM latency and write hold.
      wr(32'h0000_1234, 8'hA5);
      rd(32'h0000_1234, 8'hA5);
      wr(32'h0000_0010, 8'h77);
      idle();
      cmp("wr_hold_mem_din", 32'(mem_din), 32'hA5);
      rd(32'h0000_0010, 8'h77);
      rd(32'hFFFC_1234, 8'hA5);

      // Unmapped region and spare I/O addresses.
      wr(32'h0000_5000, 8'h3C);
      wr(32'h0002_5000, 8'hFF);
      rd(32'h0002_5000, 8'h00);
      rd(32'h0000_5000, 8'h3C);
      wr(32'h0003_0001, 8'h11);
      rd(32'h0003_0001, 8'h00);
      rd(32'h0003_0008, 8'h00);

      // RX path.
      rxp(8'h41);
      rxp(8'h42);
      rd(A_UART, 8'h41);
      rd(A_UART, 8'h42);
      rd(A_UART, 8'h00);
      idle();
      cmp("rx_ready_after_pops", 32'(rx_ready), 32'h1);
      cyc(A_UART, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h00);
      rd(A_UART, 8'h5A);
      rd(A_UART, 8'h00);
      for (int i = 0; i < 8; i++) rxp(8'(32'h10 + i));
      idle();
      cmp("rx_ready_full", 32'(rx_ready), 32'h0);
      rxp(8'h99);
      for (int i = 0; i < 8; i++) rd(A_UART, 8'(32'h10 + i));
      rd(A_UART, 8'h00);
      idle();
      cmp("rx_ready_drained", 32'(rx_ready), 32'h1);

      // TX path with host stalled.
      wr(A_UART, 8'h00);
      for (int i = 0; i < 7; i++) begin
         wr(A_UART, 8'(32'h51 + i));
         tx_exp.push_back(8'(32'h51 + i));
      end
      idle();
      cmp("tx_full_at7",  32'(tx_full),  32'h0);
      cmp("tx_valid_at7", 32'(tx_valid), 32'h1);
      wr(A_UART, 8'h58);
      tx_exp.push_back(8'h58);
      idle();
      cmp("tx_full_at8", 32'(tx_full), 32'h1);
      wr(A_UART, 8'h59);
      idle();
      cmp("tx_full_at9", 32'(tx_full), 32'h1);
      tx_ready = 1'b1;
      for (int i = 0; i < 12; i++) idle();
      cmp("tx_drained",       32'(tx_exp.size()), 32'h0);
      cmp("tx_valid_drained", 32'(tx_valid),      32'h0);

      // Halt.
      tx_exp.push_back(8'h00);
      wr(A_CLK, 8'h5A);
      wr(A_UART, 8'h61);
      wr(A_UART, 8'h62);
      idle();
      cmp("halt_set", 32'(halt), 32'h1);
      for (int i = 0; i < 4; i++) idle();
      cmp("halt_tx_drained", 32'(tx_exp.size()), 32'h0);
      cmp("halt_tx_valid",   32'(tx_valid),      32'h0);

      // Reset during a read: aborted read returns 0, RAM survives.
      @(negedge clk_in);
      mem_a   = 32'h0000_1234;
      mem_wr  = 1'b0;
      rst_in  = 1'b0;
      chk_req = 1'b1;
      rd_exp.push_back(8'h00);
      @(negedge clk_in);
      rst_in  = 1'b1;
      mem_a   = 32'h0;
      chk_req = 1'b0;
      cmp("rst2_halt",     32'(halt),     32'h0);
      cmp("rst2_tx_full",  32'(tx_full),  32'h0);
      cmp("rst2_rx_ready", 32'(rx_ready), 32'h1);
      rd(32'h0000_1234, 8'hA5);
      idle();
      idle();
      cmp("rd_queue_empty", 32'(rd_exp.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
